// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter: NREQ shift requesters in, one result out.
interface shift_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ*5-1:0] req_shamt;
  logic [NREQ*2-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [1:0]        rsp_id;

  modport master (
    output req_valid, req_data, req_shamt, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shared 5-stage log shifter (SLL/SRL/SRA/ROR)
// into a single registered result slot with valid/ready backpressure.
module shift_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_e        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    rsp_id_q;
  logic [N-1:0]  rsp_data_q;

  logic            can_accept;
  logic            gnt_found;
  logic [1:0]      gnt_idx;
  logic [1:0]      scan_idx;
  logic [NREQ-1:0] gnt_oh;
  logic            accept;

  // Search upward from ptr with wrap; first valid requester wins.
  always_comb begin
    can_accept = (state_q == EMPTY) || bus.rsp_ready;
    gnt_found  = 1'b0;
    gnt_idx    = ptr_q;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!gnt_found && bus.req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    gnt_oh = '0;
    if (gnt_found && can_accept && !rst) gnt_oh[gnt_idx] = 1'b1;
  end

  assign accept        = |gnt_oh;
  assign bus.req_ready = gnt_oh;

  logic [N-1:0] opnd;
  logic [4:0]   shamt;
  logic [1:0]   op;
  logic [N-1:0] stage [0:5];
  logic [N-1:0] shifted;

  always_comb begin
    opnd  = bus.req_data[gnt_idx*N +: N];
    shamt = bus.req_shamt[gnt_idx*5 +: 5];
    op    = bus.req_op[gnt_idx*2 +: 2];
  end

  // Stage s shifts by 2**s; SRA keeps bit 31 intact through every stage so
  // the fill stays the original sign.
  always_comb begin
    shifted  = '0;
    stage[0] = opnd;
    for (int unsigned s = 0; s < 5; s++) begin
      case (op)
        OP_SLL:  shifted = stage[s] << (1 << s);
        OP_SRL:  shifted = stage[s] >> (1 << s);
        OP_SRA:  shifted = $unsigned($signed(stage[s]) >>> (1 << s));
        default: shifted = (stage[s] >> (1 << s)) | (stage[s] << (N - (1 << s)));
      endcase
      stage[s+1] = shamt[s] ? shifted : stage[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else if (accept) begin
      state_q    <= FULL;
      rsp_data_q <= stage[5];
      rsp_id_q   <= gnt_idx;
      ptr_q      <= gnt_idx + 2'd1;
    end else if (state_q == FULL && bus.rsp_ready) begin
      state_q <= EMPTY;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter N, default 32: data width; only N=32 is supported.
REQ-002 Parameter NREQ, default 4: number of requesters; only NREQ=4 is supported.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ: requester i has a shift operation pending.
REQ-006 Port req_ready, output, NREQ: one-hot-or-zero grant; requester i's operation is accepted on any edge where req_valid[i] and req_ready[i] are both high.
REQ-007 Port req_data, input, NREQ*N: operand for requester i in bits [i*N +: N].
REQ-008 Port req_shamt, input, NREQ*5: shift amount 0..31 for requester i in bits [i*5 +: 5].
REQ-009 Port req_op, input, NREQ*2: operation for requester i in bits [i*2 +: 2]; 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port rsp_valid, output, 1: result register holds a valid result.
REQ-011 Port rsp_ready, input, 1: consumer accepts the result on any edge where rsp_valid and rsp_ready are both high.
REQ-012 Port rsp_data, output, N: shifted result.
REQ-013 Port rsp_id, output, 2: index of the requester that produced rsp_data.

Function
REQ-014 The block SHALL contain exactly one shared 32-bit, 5-stage logarithmic shifter datapath, with a 2:1 mux per stage, covering all four ops.
REQ-015 SLL/SRL SHALL fill vacated bits with 0; SRA SHALL fill with operand bit 31; ROR SHALL wrap bits shifted out of bit 0 into bit 31.
REQ-016 shamt=0 SHALL return the operand unchanged for every op.
REQ-017 The FSM has two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-018 can_accept = (state==EMPTY) or (rsp_valid and rsp_ready); req_ready SHALL be all-zero when can_accept=0 or rst=1.
REQ-019 The grant SHALL go to the first requester with req_valid high, searching upward (with wrap) from the priority pointer ptr.
REQ-020 req_ready SHALL be combinational from req_valid, ptr and state; the grant is never asserted to a requester whose req_valid is low.
REQ-021 On an accept edge, rsp_data SHALL load the shifted result, rsp_id SHALL load the granted index, the state SHALL go to FULL, and ptr SHALL load (granted index + 1) mod 4.
REQ-022 Latency SHALL be 1 cycle: the result is visible on rsp_valid/rsp_data the cycle after acceptance.
REQ-023 In FULL with rsp_ready=0, rsp_data, rsp_id and rsp_valid SHALL hold stable and ptr SHALL not change.
REQ-024 A drain (FULL, rsp_ready=1) with no accept on the same edge SHALL move the state to EMPTY; rsp_data and rsp_id hold their old values.
REQ-025 A drain and an accept on the same edge SHALL keep the state FULL and load the new result, sustaining throughput of one operation per cycle.
REQ-026 ptr SHALL change only on an accept edge; with no valid requests it stays put.
REQ-027 A requester that deasserts req_valid without being granted SHALL be dropped without side effects.

Reset
REQ-028 While rst=1 at an edge: state <= EMPTY, rsp_valid <= 0, rsp_data <= 0, rsp_id <= 0, ptr <= 0.
REQ-029 While rst=1, req_ready SHALL be all-zero.
REQ-030 Reset asserted while FULL SHALL discard the held result; no partial response is ever produced.

Verification
REQ-031 Ops: requester 0 issues SLL 0x00000001 by 31 -> rsp_data 0x80000000, id 0. SRL 0x80000000 by 31 -> 0x00000001. SRA 0x80000000 by 4 -> 0xF8000000. ROR 0x00000001 by 1 -> 0x80000000. shamt 0 with 0xDEADBEEF -> 0xDEADBEEF for all ops.
REQ-032 Round-robin: all four req_valid held high with rsp_ready=1 from reset -> grants go 0,1,2,3,0; one rsp_valid per cycle with rsp_id matching.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles while FULL -> req_ready stays 0000 and rsp_data is stable; rsp_ready=1 -> same-edge drain and accept of the next request.
REQ-034 Skip: only req_valid[2] high with ptr=3 -> grant 2 and ptr becomes 3; then req_valid = 0011 -> grant 0.
REQ-035 Reset mid-operation: rst pulsed while FULL with rsp_ready=0 -> next cycle rsp_valid=0, rsp_data=0, rsp_id=0, and the first grant after reset goes to the lowest valid index.
REQ-036 Randomized: 10k random ops with random valid/ready against a reference model -> no lost, duplicated or reordered results per requester, and no requester starved beyond 3 intervening grants.
